// File: rtl/huffman_pkg.sv
// Shared constants for the canonical-Huffman decoder: widths, code table and EOM.
// Codewords are stored left-aligned in a 5-bit field with unused low bits zero.
package huffman_pkg;

  localparam int C_WIDTH     = 4;
  localparam int VLC_WIDTH   = 5;
  localparam int VLCZ_WIDTH  = 3;
  localparam int P_WIDTH     = 32;
  localparam int P_WIDTH_MSB = P_WIDTH - 1;
  localparam int BUF_WIDTH   = 2 * P_WIDTH;
  localparam int CNT_WIDTH   = 7;
  localparam int NUM_SYMS    = 16;

  localparam logic [VLC_WIDTH-1:0]  EOM        = 5'b11111;
  localparam logic [VLCZ_WIDTH-1:0] EOM_LENGTH = 3'd4;

  // Index i holds the codeword / length-1 of symbol i.
  localparam logic [NUM_SYMS-1:0][VLC_WIDTH-1:0] SYM_CODE = {
    5'b11110, 5'b11101, 5'b11100, 5'b11011, 5'b11010, 5'b11001, 5'b11000,
    5'b10110, 5'b10100, 5'b10010, 5'b10000, 5'b01110, 5'b01100,
    5'b01000, 5'b00100, 5'b00000
  };

  localparam logic [NUM_SYMS-1:0][VLCZ_WIDTH-1:0] SYM_LEN_M1 = {
    3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
    3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
    3'd2, 3'd2, 3'd2
  };

  typedef struct packed {
    logic [C_WIDTH-1:0]    symbol;
    logic [VLCZ_WIDTH-1:0] len_m1;
    logic                  is_eom;
  } lut_out_t;

  function automatic logic [VLC_WIDTH-1:0] len_mask(input logic [VLCZ_WIDTH-1:0] len_m1);
    return 5'b11111 << (3'd4 - len_m1);
  endfunction

endpackage

// File: rtl/huffman_if.sv
// Word-source and symbol-sink signals of the decoder.
// Source side: idata is captured at a rising edge where rdy=1 and pop=1.
// Sink side: code is valid at an edge where push=1; push only follows a cycle with not_full=1.
interface huffman_if;
  import huffman_pkg::*;

  logic [P_WIDTH-1:0] idata;
  logic               rdy;
  logic               pop;
  logic               not_full;
  logic [C_WIDTH-1:0] code;
  logic               push;

  modport master (output idata, rdy, not_full, input pop, code, push);
  modport slave  (input idata, rdy, not_full, output pop, code, push);
endinterface

// File: rtl/huffman_lut.sv
// Combinational codeword match of the 5-bit decode window against the code table.
module huffman_lut
  import huffman_pkg::*;
(
  input  logic [VLC_WIDTH-1:0] window,
  output lut_out_t             result
);

  // The table is complete and prefix-free, so a window with no symbol match is EOM.
  always_comb begin
    result = '{symbol: '0, len_m1: EOM_LENGTH, is_eom: 1'b1};
    for (int i = 0; i < NUM_SYMS; i++) begin
      if ((window & len_mask(SYM_LEN_M1[i])) == SYM_CODE[i]) begin
        result.symbol = C_WIDTH'(i);
        result.len_m1 = SYM_LEN_M1[i];
        result.is_eom = 1'b0;
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Streaming canonical-Huffman decoder: 64-bit left-aligned bit buffer refilled
// from 32-bit words, one symbol decoded per cycle from the top 5 bits.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  huffman_if.slave  bus
);

  logic [BUF_WIDTH-1:0] bit_buf;
  logic [CNT_WIDTH-1:0] cnt;
  logic [C_WIDTH-1:0]   code_q;
  logic                 push_q;
  lut_out_t             lut;

  logic                 decode;
  logic [CNT_WIDTH-1:0] len;
  logic [CNT_WIDTH-1:0] discard;
  logic [CNT_WIDTH-1:0] shift;
  logic [CNT_WIDTH-1:0] remain;
  logic                 pop;
  logic [BUF_WIDTH-1:0] shifted;
  logic [BUF_WIDTH-1:0] incoming;

  huffman_lut u_lut (
    .window (bit_buf[BUF_WIDTH-1 -: VLC_WIDTH]),
    .result (lut)
  );

  always_comb begin
    decode   = (cnt >= 7'd5) && bus.not_full;
    len      = decode ? (CNT_WIDTH'(lut.len_m1) + 7'd1) : 7'd0;
    // After EOM the rest of the word holding the next bit is dropped; any full
    // word buffered behind it is a multiple of 32 and survives the modulo.
    discard  = (decode && lut.is_eom) ? ((cnt - 7'd5) & 7'd31) : 7'd0;
    shift    = len + discard;
    remain   = cnt - shift;
    pop      = reset && bus.rdy && ((cnt - len) <= 7'd32);
    shifted  = bit_buf << shift;
    incoming = {bus.idata, {P_WIDTH{1'b0}}} >> remain;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_buf <= '0;
      cnt     <= '0;
      code_q  <= '0;
      push_q  <= 1'b0;
    end else begin
      bit_buf <= pop ? (shifted | incoming) : shifted;
      cnt     <= remain + (pop ? 7'd32 : 7'd0);
      push_q  <= decode && !lut.is_eom;
      if (decode && !lut.is_eom) code_q <= lut.symbol;
    end
  end

  assign bus.pop  = pop;
  assign bus.push = push_q;
  assign bus.code = code_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Randomized scoreboard bench for huffman_decoder against a bit-queue reference model.
module tb_huffman_decoder;
  import huffman_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  huffman_if bus();

  huffman_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  got_q[$];
  logic [31:0] src_q[$];
  bit          m_bits[$];
  int          m_pos = 0;
  bit          rdy_en = 1'b1;
  bit          rdy_rand = 1'b0;
  int          nf_mode = 1;
  int          push_count = 0;
  int          pop_count = 0;
  logic        nf_at_edge = 1'b1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // ---------------- reference model: bitstream with word alignment ----------------
  function automatic int peek(input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = v * 2 + int'(m_bits[i]);
    return v;
  endfunction

  function automatic void drop(input int n);
    for (int i = 0; i < n; i++) void'(m_bits.pop_front());
  endfunction

  task automatic model_word(input logic [31:0] w);
    int len;
    int sym;
    bit eom;
    for (int i = 31; i >= 0; i--) m_bits.push_back(w[i]);
    while (m_bits.size() >= 5) begin
      eom = 1'b0;
      if (peek(3) < 3) begin
        len = 3; sym = peek(3);
      end else if (peek(4) < 12) begin
        len = 4; sym = peek(4) - 3;
      end else if (peek(5) == 31) begin
        len = 5; sym = 0; eom = 1'b1;
      end else begin
        len = 5; sym = peek(5) - 15;
      end
      drop(len);
      m_pos = (m_pos + len) % 32;
      if (eom) begin
        drop((32 - m_pos) % 32);
        m_pos = 0;
      end else begin
        exp_q.push_back(4'(sym));
      end
    end
  endtask

  // ---------------- driver: word source and sink backpressure ----------------
  initial begin
    bus.idata = '0;
    bus.rdy = 1'b0;
    bus.not_full = 1'b1;
    forever begin
      @(negedge clk);
      case (nf_mode)
        0: bus.not_full = 1'b0;
        1: bus.not_full = 1'b1;
        default: bus.not_full = ($urandom_range(0, 3) != 0);
      endcase
      bus.rdy = rdy_en && (src_q.size() > 0) && (!rdy_rand || $urandom_range(0, 2) != 0);
      bus.idata = (src_q.size() > 0) ? src_q[0] : 32'd0;
      #4;
      if (bus.pop && !bus.rdy) check("pop_without_rdy", 1, 0);
      if (bus.pop && src_q.size() > 0) begin
        pop_count++;
        model_word(src_q.pop_front());
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) nf_at_edge = bus.not_full;

  always @(negedge clk) begin
    logic [3:0] e;
    if (bus.push) begin
      push_count++;
      if (!nf_at_edge) check("push_while_full", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_push", int'(bus.code), -1);
      end else begin
        e = exp_q.pop_front();
        check("symbol", int'(bus.code), int'(e));
      end
      got_q.push_back(bus.code);
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2;
    reset = 1'b0;
    m_bits.delete();
    m_pos = 0;
    exp_q.delete();
    got_q.delete();
    repeat (cycles) begin
      @(negedge clk);
      #3;
      check("reset_push", int'(bus.push), 0);
      check("reset_code", int'(bus.code), 0);
      check("reset_pop", int'(bus.pop), 0);
    end
    reset = 1'b1;
  endtask

  task automatic wait_src(input int limit);
    int n = 0;
    while (src_q.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("src_drain", src_q.size(), 0);
    repeat (40) @(negedge clk);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0: src_q.push_back(32'h0000_0000);
        1: src_q.push_back($urandom | 32'hF800_0000);
        default: src_q.push_back($urandom);
      endcase
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, p0, d;
    int dir_exp[12] = '{3, 15, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2};

    // directed message examples, queued before reset release
    src_q.push_back(32'h6F00_0000);
    src_q.push_back(32'hFFFF_FFFF);
    src_q.push_back(32'h1FFF_FFFF);
    src_q.push_back(32'h5FFF_FFFF);
    do_reset(3);
    repeat (60) @(negedge clk);
    check("dir_count", got_q.size(), 12);
    for (int i = 0; i < 12; i++)
      check("dir_symbol", (i < got_q.size()) ? int'(got_q[i]) : -1, dir_exp[i]);

    // random words with random rdy and backpressure
    nf_mode = 2;
    rdy_rand = 1'b1;
    add_random(80);
    wait_src(4000);

    // long backpressure stall
    nf_mode = 1;
    rdy_rand = 1'b0;
    add_random(20);
    repeat (10) @(negedge clk);
    nf_mode = 0;
    repeat (2) @(negedge clk);
    c0 = push_count;
    p0 = pop_count;
    repeat (298) @(negedge clk);
    #5;
    check("stall_pushes", push_count - c0, 0);
    check("stall_pops_le2", int'((pop_count - p0) <= 2), 1);
    check("stall_rdy", int'(bus.rdy), 1);
    check("stall_pop_low", int'(bus.pop), 0);
    nf_mode = 1;
    wait_src(2000);

    // all-zero stream: one push every cycle, about 3/32 pops per cycle
    for (int i = 0; i < 40; i++) src_q.push_back(32'h0);
    repeat (20) @(negedge clk);
    c0 = push_count;
    p0 = pop_count;
    repeat (200) @(negedge clk);
    check("zero_pushes", push_count - c0, 200);
    d = pop_count - p0;
    check("zero_pop_rate", int'(d >= 18 && d <= 20), 1);
    wait_src(2000);

    // source stalls while buffer drains, then resumes with straddling codes
    add_random(10);
    repeat (5) @(negedge clk);
    rdy_en = 1'b0;
    repeat (40) @(negedge clk);
    c0 = push_count;
    repeat (10) @(negedge clk);
    check("drain_no_push", push_count - c0, 0);
    rdy_en = 1'b1;
    nf_mode = 2;
    rdy_rand = 1'b1;
    wait_src(2000);

    // reset in the middle of a stream
    add_random(30);
    repeat (50) @(negedge clk);
    do_reset(2);
    wait_src(4000);
    nf_mode = 1;
    repeat (40) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
